// File: rtl/stack_core_pkg.sv
// Shared definitions for the stack_core processor: FSM states, instruction
// word classes, byte opcodes, fault codes, and per-opcode stack-effect helpers.
package stack_core_pkg;

  typedef enum logic [2:0] {
    FETCH,
    EXEC_W,
    EXEC_HI,
    EXEC_LO,
    HALT
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_DS_OVF = 2'd1,
    ERR_DS_UNF = 2'd2,
    ERR_RS     = 2'd3
  } err_e;

  // Word classes in ir[15:13] when ir[15]=0 (ir[15]=1 is LIT).
  localparam logic [2:0] WC_JZ   = 3'b001;
  localparam logic [2:0] WC_CALL = 3'b010;
  localparam logic [2:0] WC_JMP  = 3'b011;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_DUP  = 8'h03;
  localparam logic [7:0] OP_SWAP = 8'h04;
  localparam logic [7:0] OP_DROP = 8'h05;
  localparam logic [7:0] OP_OUT  = 8'h06;
  localparam logic [7:0] OP_RET  = 8'h07;
  localparam logic [7:0] OP_AND  = 8'h08;
  localparam logic [7:0] OP_OR   = 8'h09;
  localparam logic [7:0] OP_XOR  = 8'h0A;
  localparam logic [7:0] OP_OVER = 8'h0B;
  localparam logic [7:0] OP_HALT = 8'h0C;

  // Number of data-stack operands a byte op consumes or inspects.
  function automatic logic [1:0] op_need(input logic [7:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SWAP, OP_OVER: op_need = 2'd2;
      OP_DUP, OP_DROP, OP_OUT:                                 op_need = 2'd1;
      default:                                                 op_need = 2'd0;
    endcase
  endfunction

  // Byte ops that grow the data stack by one entry.
  function automatic logic op_pushes(input logic [7:0] op);
    op_pushes = (op == OP_DUP) || (op == OP_OVER);
  endfunction

endpackage

// File: rtl/stack_core_lifo.sv
// lifo_stack: register-file LIFO used for both the data and return stacks.
// Ports: i_push/i_pop adjust occupancy; i_wr rewrites the resulting top entry
// and i_wr_nos the entry below it, so pop+wr implements "pop two, push one".
// o_tos/o_nos read the current top two entries; o_full/o_depth report occupancy.
module lifo_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_wr,
  input  logic                     i_wr_nos,
  input  logic [WIDTH-1:0]         i_data,
  input  logic [WIDTH-1:0]         i_nos_data,
  output logic [WIDTH-1:0]         o_tos,
  output logic [WIDTH-1:0]         o_nos,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_depth
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DW-1:0]    r_depth;
  logic [DW-1:0]    w_depth_nxt;
  logic [AW-1:0]    w_top;
  logic [AW-1:0]    w_top_nxt;

  assign w_depth_nxt = r_depth + DW'(i_push) - DW'(i_pop);
  // Index arithmetic wraps mod DEPTH; reads at depth 0/1 are don't-care.
  assign w_top       = AW'(r_depth - DW'(1));
  assign w_top_nxt   = AW'(w_depth_nxt - DW'(1));

  assign o_tos   = r_mem[w_top];
  assign o_nos   = r_mem[w_top - AW'(1)];
  assign o_full  = (r_depth == DW'(DEPTH));
  assign o_depth = r_depth;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_depth <= '0;
    else        r_depth <= w_depth_nxt;
  end

  always_ff @(posedge clk) begin
    if (i_push || i_wr) r_mem[w_top_nxt] <= i_data;
    if (i_wr_nos)       r_mem[w_top_nxt - AW'(1)] <= i_nos_data;
  end

endmodule

// File: rtl/stack_core.sv
// stack_core: 16-bit-instruction stack processor.
// Ports: mem_addr/mem_req/mem_ack/mem_rdata fetch instruction words;
// out_valid/out_data/out_ready stream OUT values; halted/err report a stop
// and its cause; ds_depth exposes data-stack occupancy for debug.
module stack_core
  import stack_core_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 15,
  parameter int DS_DEPTH = 16,
  parameter int RS_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_req,
  input  logic                      mem_ack,
  input  logic [15:0]               mem_rdata,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic                      halted,
  output logic [1:0]                err,
  output logic [$clog2(DS_DEPTH):0] ds_depth
);
  localparam int DSW = $clog2(DS_DEPTH) + 1;
  localparam int RSW = $clog2(RS_DEPTH) + 1;

  state_e              r_state, w_state_nxt;
  err_e                r_err, w_err_nxt;
  logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
  logic [15:0]         r_ir;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                w_fault, w_pc_load, w_out_set, w_out_clr;
  logic [7:0]          w_op;
  logic [DATA_W-1:0]   w_alu;

  logic                w_ds_push, w_ds_pop, w_ds_wr, w_ds_wr_nos, w_ds_full;
  logic [DATA_W-1:0]   w_ds_wdata, w_ds_nos_wdata, w_ds_tos, w_ds_nos;
  logic [DSW-1:0]      w_ds_depth;
  logic                w_rs_push, w_rs_pop, w_rs_full;
  logic [ADDR_W-1:0]   w_rs_tos, w_rs_nos_unused;
  logic [RSW-1:0]      w_rs_depth;

  function automatic logic [DATA_W-1:0] alu(input logic [7:0] op,
                                            input logic [DATA_W-1:0] nos,
                                            input logic [DATA_W-1:0] tos);
    case (op)
      OP_ADD:  alu = nos + tos;
      OP_SUB:  alu = nos - tos;
      OP_AND:  alu = nos & tos;
      OP_OR:   alu = nos | tos;
      OP_XOR:  alu = nos ^ tos;
      default: alu = tos;
    endcase
  endfunction

  assign w_op  = (r_state == EXEC_HI) ? r_ir[15:8] : r_ir[7:0];
  assign w_alu = alu(w_op, w_ds_nos, w_ds_tos);

  always_comb begin
    w_state_nxt    = r_state;
    w_err_nxt      = ERR_NONE;
    w_fault        = 1'b0;
    w_pc_load      = 1'b0;
    w_pc_nxt       = ADDR_W'(r_ir[12:0]);
    w_out_set      = 1'b0;
    w_out_clr      = 1'b0;
    w_ds_push      = 1'b0;
    w_ds_pop       = 1'b0;
    w_ds_wr        = 1'b0;
    w_ds_wr_nos    = 1'b0;
    w_ds_wdata     = w_ds_tos;
    w_ds_nos_wdata = w_ds_tos;
    w_rs_push      = 1'b0;
    w_rs_pop       = 1'b0;
    case (r_state)
      FETCH: begin
        if (mem_ack) w_state_nxt = (mem_rdata[15:13] != 3'b000) ? EXEC_W : EXEC_HI;
      end
      EXEC_W: begin
        w_state_nxt = FETCH;
        if (r_ir[15]) begin
          if (w_ds_full) begin
            w_fault = 1'b1; w_err_nxt = ERR_DS_OVF;
          end else begin
            w_ds_push  = 1'b1;
            w_ds_wdata = DATA_W'(r_ir[14:0]);
          end
        end else begin
          case (r_ir[15:13])
            WC_CALL: begin
              if (w_rs_full) begin
                w_fault = 1'b1; w_err_nxt = ERR_RS;
              end else begin
                w_rs_push = 1'b1;
                w_pc_load = 1'b1;
              end
            end
            WC_JMP: w_pc_load = 1'b1;
            WC_JZ: begin
              if (w_ds_depth == '0) begin
                w_fault = 1'b1; w_err_nxt = ERR_DS_UNF;
              end else begin
                w_ds_pop  = 1'b1;
                w_pc_load = (w_ds_tos == '0);
              end
            end
            default: ;
          endcase
        end
      end
      EXEC_HI, EXEC_LO: begin
        w_state_nxt = (r_state == EXEC_HI) ? EXEC_LO : FETCH;
        if (DSW'(op_need(w_op)) > w_ds_depth) begin
          w_fault = 1'b1; w_err_nxt = ERR_DS_UNF;
        end else if (op_pushes(w_op) && w_ds_full) begin
          w_fault = 1'b1; w_err_nxt = ERR_DS_OVF;
        end else if ((w_op == OP_RET) && (w_rs_depth == '0)) begin
          w_fault = 1'b1; w_err_nxt = ERR_RS;
        end else begin
          case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              w_ds_pop   = 1'b1;
              w_ds_wr    = 1'b1;
              w_ds_wdata = w_alu;
            end
            OP_DUP: w_ds_push = 1'b1;
            OP_OVER: begin
              w_ds_push  = 1'b1;
              w_ds_wdata = w_ds_nos;
            end
            OP_SWAP: begin
              w_ds_wr     = 1'b1;
              w_ds_wdata  = w_ds_nos;
              w_ds_wr_nos = 1'b1;
            end
            OP_DROP: w_ds_pop = 1'b1;
            OP_OUT: begin
              // First cycle in the slot publishes TOS; the pop happens on handshake.
              if (!r_out_valid) begin
                w_out_set   = 1'b1;
                w_state_nxt = r_state;
              end else if (out_ready) begin
                w_out_clr = 1'b1;
                w_ds_pop  = 1'b1;
              end else begin
                w_state_nxt = r_state;
              end
            end
            OP_RET: begin
              w_rs_pop    = 1'b1;
              w_pc_load   = 1'b1;
              w_pc_nxt    = w_rs_tos;
              w_state_nxt = FETCH;
            end
            OP_HALT: w_state_nxt = HALT;
            default: ;
          endcase
        end
      end
      default: w_state_nxt = HALT;
    endcase
    if (w_fault) w_state_nxt = HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FETCH;
      r_pc        <= '0;
      r_err       <= ERR_NONE;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == FETCH) && mem_ack) r_pc <= r_pc + ADDR_W'(1);
      else if (w_pc_load)                r_pc <= w_pc_nxt;
      if (w_fault) r_err <= w_err_nxt;
      if (w_out_set) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_ds_tos;
      end else if (w_out_clr) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == FETCH) && mem_ack) r_ir <= mem_rdata;
  end

  lifo_stack #(.WIDTH(DATA_W), .DEPTH(DS_DEPTH)) u_ds (
    .clk(clk), .rst_n(rst_n),
    .i_push(w_ds_push), .i_pop(w_ds_pop), .i_wr(w_ds_wr), .i_wr_nos(w_ds_wr_nos),
    .i_data(w_ds_wdata), .i_nos_data(w_ds_nos_wdata),
    .o_tos(w_ds_tos), .o_nos(w_ds_nos), .o_full(w_ds_full), .o_depth(w_ds_depth)
  );

  lifo_stack #(.WIDTH(ADDR_W), .DEPTH(RS_DEPTH)) u_rs (
    .clk(clk), .rst_n(rst_n),
    .i_push(w_rs_push), .i_pop(w_rs_pop), .i_wr(1'b0), .i_wr_nos(1'b0),
    .i_data(r_pc), .i_nos_data('0),
    .o_tos(w_rs_tos), .o_nos(w_rs_nos_unused), .o_full(w_rs_full), .o_depth(w_rs_depth)
  );

  assign mem_addr  = r_pc;
  assign mem_req   = (r_state == FETCH) && rst_n;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign halted    = (r_state == HALT);
  assign err       = r_err;
  assign ds_depth  = w_ds_depth;

endmodule

// File: tb/tb_stack_core.sv
module tb_stack_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic mem_ack = 1'b1;
  logic out_ready = 1'b1;
  logic [15:0] prog [0:32767];

  logic [14:0] a_addr, b_addr, c_addr;
  logic        a_req, b_req, c_req;
  logic [15:0] a_rdata, b_rdata, c_rdata;
  logic        a_valid, b_valid, c_valid;
  logic [15:0] a_data, b_data;
  logic [31:0] c_data;
  logic        a_halted, b_halted, c_halted;
  logic [1:0]  a_err, b_err, c_err;
  logic [4:0]  a_depth, c_depth;
  logic [2:0]  b_depth;

  assign a_rdata = prog[a_addr];
  assign b_rdata = prog[b_addr];
  assign c_rdata = prog[c_addr];

  stack_core u_a (.clk(clk), .rst_n(rst_n), .mem_addr(a_addr), .mem_req(a_req), .mem_ack(mem_ack),
    .mem_rdata(a_rdata), .out_valid(a_valid), .out_data(a_data), .out_ready(out_ready),
    .halted(a_halted), .err(a_err), .ds_depth(a_depth));
  stack_core #(.DS_DEPTH(4)) u_b (.clk(clk), .rst_n(rst_n), .mem_addr(b_addr), .mem_req(b_req),
    .mem_ack(mem_ack), .mem_rdata(b_rdata), .out_valid(b_valid), .out_data(b_data),
    .out_ready(out_ready), .halted(b_halted), .err(b_err), .ds_depth(b_depth));
  stack_core #(.DATA_W(32)) u_c (.clk(clk), .rst_n(rst_n), .mem_addr(c_addr), .mem_req(c_req),
    .mem_ack(mem_ack), .mem_rdata(c_rdata), .out_valid(c_valid), .out_data(c_data),
    .out_ready(out_ready), .halted(c_halted), .err(c_err), .ds_depth(c_depth));

  int checks = 0;
  int failures = 0;
  int va_cycles;
  longint unsigned got_q [3][$];
  longint unsigned exp_q [3][$];
  int exp_err [3];
  int exp_depth [3];

  // ISA-level reference model: queues as stacks, executes words in program order.
  longint unsigned mds[$];
  int mrs[$];
  longint unsigned m_out[$];
  int mpc, merr, m_depth, mcap;
  bit mdone;
  longint unsigned mmask;

  task automatic m_fault(input int code);
    merr = code;
    mdone = 1'b1;
  endtask

  task automatic m_byte(input logic [7:0] op, output bit skip);
    longint unsigned t, n;
    int need;
    bit psh;
    skip = 1'b0;
    need = (op inside {8'h01, 8'h02, 8'h04, 8'h08, 8'h09, 8'h0A, 8'h0B}) ? 2 :
           (op inside {8'h03, 8'h05, 8'h06}) ? 1 : 0;
    psh = op inside {8'h03, 8'h0B};
    if (mds.size() < need) begin m_fault(2); return; end
    if (psh && mds.size() == mcap) begin m_fault(1); return; end
    if (op == 8'h07 && mrs.size() == 0) begin m_fault(3); return; end
    case (op)
      8'h01, 8'h02, 8'h08, 8'h09, 8'h0A: begin
        t = mds.pop_back();
        n = mds.pop_back();
        case (op)
          8'h01:   mds.push_back((n + t) & mmask);
          8'h02:   mds.push_back((n - t) & mmask);
          8'h08:   mds.push_back(n & t);
          8'h09:   mds.push_back(n | t);
          default: mds.push_back(n ^ t);
        endcase
      end
      8'h03: mds.push_back(mds[$]);
      8'h04: begin
        t = mds.pop_back();
        n = mds.pop_back();
        mds.push_back(t);
        mds.push_back(n);
      end
      8'h05: void'(mds.pop_back());
      8'h06: m_out.push_back(mds.pop_back());
      8'h07: begin mpc = mrs.pop_back(); skip = 1'b1; end
      8'h0B: mds.push_back(mds[mds.size()-2]);
      8'h0C: mdone = 1'b1;
      default: ;
    endcase
  endtask

  task automatic model_run(input int cap, input int dw);
    logic [15:0] w;
    bit skip;
    mds.delete(); mrs.delete(); m_out.delete();
    mpc = 0; merr = 0; mdone = 1'b0; mcap = cap;
    mmask = (64'd1 << dw) - 64'd1;
    for (int s = 0; s < 4000 && !mdone; s++) begin
      w = prog[mpc];
      mpc = (mpc + 1) % 32768;
      if (w[15]) begin
        if (mds.size() == cap) m_fault(1);
        else mds.push_back(w[14:0]);
      end else if (w[15:13] == 3'b010) begin
        if (mrs.size() == 8) m_fault(3);
        else begin mrs.push_back(mpc); mpc = w[12:0]; end
      end else if (w[15:13] == 3'b011) begin
        mpc = w[12:0];
      end else if (w[15:13] == 3'b001) begin
        if (mds.size() == 0) m_fault(2);
        else if (mds.pop_back() == 0) mpc = w[12:0];
      end else begin
        m_byte(w[15:8], skip);
        if (!mdone && !skip) m_byte(w[7:0], skip);
      end
    end
    m_depth = mds.size();
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32768; i++) prog[i] = 16'h0000;
  endtask

  task automatic load_basic();
    clear_prog();
    prog[0] = 16'h8005; prog[1] = 16'h8003; prog[2] = 16'h0206; prog[3] = 16'h0C00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ack = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_all(input int budget, input int rdy_pct, input int ack_pct);
    for (int k = 0; k < 3; k++) got_q[k].delete();
    va_cycles = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(99) < rdy_pct);
      mem_ack   = ($urandom_range(99) < ack_pct);
      #1;
      if (a_valid) va_cycles++;
      if (a_valid && out_ready) got_q[0].push_back(a_data);
      if (b_valid && out_ready) got_q[1].push_back(b_data);
      if (c_valid && out_ready) got_q[2].push_back(c_data);
      if (a_halted && b_halted && c_halted) break;
    end
    checks++;
    if (!(a_halted && b_halted && c_halted)) begin
      failures++;
      $display("FAIL run_timeout halted a=%b b=%b c=%b required 111", a_halted, b_halted, c_halted);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ack = 1'b1; out_ready = 1'b1;
    #1;
    checks += 7;
    if (a_req !== 1'b0)    begin failures++; $display("FAIL rst_mem_req got=%b required=0", a_req); end
    if (a_valid !== 1'b0)  begin failures++; $display("FAIL rst_out_valid got=%b required=0", a_valid); end
    if (a_data !== 16'h0)  begin failures++; $display("FAIL rst_out_data got=%h required=0", a_data); end
    if (a_halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%b required=0", a_halted); end
    if (a_err !== 2'd0)    begin failures++; $display("FAIL rst_err got=%0d required=0", a_err); end
    if (a_depth !== 5'd0)  begin failures++; $display("FAIL rst_ds_depth got=%0d required=0", a_depth); end
    if (a_addr !== 15'd0)  begin failures++; $display("FAIL rst_mem_addr got=%h required=0", a_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (a_req !== 1'b1) begin failures++; $display("FAIL req_after_release got=%b required=1", a_req); end
  endtask

  task automatic test_basic();
    load_basic();
    do_reset();
    @(negedge clk); #1;
    checks++;
    if (a_depth !== 5'd0) begin failures++; $display("FAIL lit_latency_c1 depth got=%0d required=0", a_depth); end
    @(negedge clk); #1;
    checks++;
    if (a_depth !== 5'd1) begin failures++; $display("FAIL lit_latency_c2 depth got=%0d required=1", a_depth); end
    run_all(200, 100, 100);
    checks += 5;
    if (got_q[0].size() != 1 || got_q[0][0] !== 64'd2)
      begin failures++; $display("FAIL basic_out count=%0d first=%0h required one value 2", got_q[0].size(), got_q[0].size() > 0 ? got_q[0][0] : 0); end
    if (va_cycles != 1) begin failures++; $display("FAIL basic_valid_cycles got=%0d required=1", va_cycles); end
    if (a_halted !== 1'b1) begin failures++; $display("FAIL basic_halted got=%b required=1", a_halted); end
    if (a_err !== 2'd0) begin failures++; $display("FAIL basic_err got=%0d required=0", a_err); end
    if (a_depth !== 5'd0) begin failures++; $display("FAIL basic_depth got=%0d required=0", a_depth); end
  endtask

  task automatic test_out_stall();
    logic [14:0] pc0;
    int n;
    load_basic();
    do_reset();
    out_ready = 1'b0;
    n = 0;
    while (!a_valid && n < 100) begin @(negedge clk); #1; n++; end
    checks++;
    if (a_valid !== 1'b1) begin failures++; $display("FAIL stall_wait_valid got=%b required=1", a_valid); end
    pc0 = a_addr;
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk);
      if (i == 6) out_ready = 1'b1;
      #1;
      checks += 3;
      if (a_valid !== 1'b1) begin failures++; $display("FAIL stall_valid c%0d got=%b required=1", i, a_valid); end
      if (a_data !== 16'd2) begin failures++; $display("FAIL stall_data c%0d got=%h required=2", i, a_data); end
      if (a_addr !== pc0) begin failures++; $display("FAIL stall_pc c%0d got=%h required=%h", i, a_addr, pc0); end
    end
    @(negedge clk); #1;
    checks++;
    if (a_valid !== 1'b0) begin failures++; $display("FAIL stall_valid_drop got=%b required=0", a_valid); end
    run_all(100, 100, 100);
    checks += 2;
    if (a_halted !== 1'b1 || a_err !== 2'd0)
      begin failures++; $display("FAIL stall_halt halted=%b err=%0d required 1/0", a_halted, a_err); end
    if (got_q[0].size() != 0) begin failures++; $display("FAIL stall_extra_out count=%0d required=0", got_q[0].size()); end
  endtask

  task automatic test_call_ret();
    for (int v = 0; v < 2; v++) begin
      clear_prog();
      prog[0] = 16'h4010; prog[1] = 16'h8007; prog[2] = 16'h060C;
      prog[16'h10] = (v == 0) ? 16'h0700 : 16'h070C;
      do_reset();
      run_all(200, 100, 100);
      checks += 3;
      if (got_q[0].size() != 1 || got_q[0][0] !== 64'd7)
        begin failures++; $display("FAIL call_ret_out v%0d count=%0d required one value 7", v, got_q[0].size()); end
      if (a_err !== 2'd0) begin failures++; $display("FAIL call_ret_err v%0d got=%0d required=0", v, a_err); end
      if (a_depth !== 5'd0) begin failures++; $display("FAIL call_ret_depth v%0d got=%0d required=0", v, a_depth); end
    end
  endtask

  task automatic test_ret_empty();
    clear_prog();
    prog[0] = 16'h070C;
    do_reset();
    run_all(100, 100, 100);
    checks += 2;
    if (a_err !== 2'd3) begin failures++; $display("FAIL ret_empty_err got=%0d required=3", a_err); end
    if (a_halted !== 1'b1) begin failures++; $display("FAIL ret_empty_halted got=%b required=1", a_halted); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (a_req !== 1'b0) begin failures++; $display("FAIL ret_empty_req c%0d got=%b required=0", i, a_req); end
    end
  endtask

  task automatic test_ds_overflow();
    clear_prog();
    for (int i = 0; i < 5; i++) prog[i] = 16'h8001 + 16'(i);
    prog[5] = 16'h0C0C;
    do_reset();
    run_all(200, 100, 100);
    checks += 4;
    if (b_err !== 2'd1) begin failures++; $display("FAIL ovf_err got=%0d required=1", b_err); end
    if (b_depth !== 3'd4) begin failures++; $display("FAIL ovf_depth got=%0d required=4", b_depth); end
    if (b_halted !== 1'b1) begin failures++; $display("FAIL ovf_halted got=%b required=1", b_halted); end
    if (a_err !== 2'd0 || a_depth !== 5'd5)
      begin failures++; $display("FAIL ovf_deep_core err=%0d depth=%0d required 0/5", a_err, a_depth); end
  endtask

  task automatic test_ds_underflow();
    clear_prog();
    prog[0] = 16'h8001; prog[1] = 16'h010C;
    do_reset();
    run_all(100, 100, 100);
    checks += 2;
    if (a_err !== 2'd2) begin failures++; $display("FAIL unf_err got=%0d required=2", a_err); end
    if (a_depth !== 5'd1) begin failures++; $display("FAIL unf_depth got=%0d required=1", a_depth); end
  endtask

  task automatic test_jz();
    for (int t = 0; t < 2; t++) begin
      clear_prog();
      prog[0] = 16'h8000 | 16'(t); prog[1] = 16'h2020;
      prog[2] = 16'h8011; prog[3] = 16'h060C;
      prog[16'h20] = 16'h8022; prog[16'h21] = 16'h060C;
      do_reset();
      run_all(200, 100, 100);
      checks += 2;
      if (got_q[0].size() != 1 || got_q[0][0] !== ((t == 0) ? 64'h22 : 64'h11))
        begin failures++; $display("FAIL jz_tos%0d_out count=%0d required one value %h", t, got_q[0].size(), (t == 0) ? 8'h22 : 8'h11); end
      if (a_depth !== 5'd0 || a_err !== 2'd0)
        begin failures++; $display("FAIL jz_tos%0d_state depth=%0d err=%0d required 0/0", t, a_depth, a_err); end
    end
  endtask

  task automatic test_reset_mid_out();
    int n;
    load_basic();
    do_reset();
    out_ready = 1'b0;
    n = 0;
    while (!a_valid && n < 100) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (a_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b required=0", a_valid); end
    if (a_addr !== 15'd0) begin failures++; $display("FAIL midrst_pc got=%h required=0", a_addr); end
    if (a_depth !== 5'd0) begin failures++; $display("FAIL midrst_depth got=%0d required=0", a_depth); end
    @(negedge clk);
    rst_n = 1'b1;
    run_all(200, 100, 100);
    checks += 2;
    if (got_q[0].size() != 1 || got_q[0][0] !== 64'd2)
      begin failures++; $display("FAIL midrst_rerun_out count=%0d required one value 2", got_q[0].size()); end
    if (a_err !== 2'd0) begin failures++; $display("FAIL midrst_err got=%0d required=0", a_err); end
  endtask

  task automatic test_wide();
    clear_prog();
    prog[0] = 16'hFFFF; prog[1] = 16'h0301; prog[2] = 16'h060C;
    do_reset();
    run_all(200, 100, 100);
    checks++;
    if (got_q[2].size() != 1 || got_q[2][0] !== 64'hFFFE)
      begin failures++; $display("FAIL wide_out count=%0d first=%0h required one value fffe", got_q[2].size(), got_q[2].size() > 0 ? got_q[2][0] : 0); end
  endtask

  task automatic test_random();
    logic [7:0] opt [14] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h06,
                             8'h08, 8'h09, 8'h0A, 8'h0B, 8'h00, 8'h0D, 8'h03};
    logic [7:0] hi, lo;
    int n, r;
    int gerr, gdep;
    for (int it = 0; it < 24; it++) begin
      clear_prog();
      n = $urandom_range(4, 14);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(99);
        hi = opt[$urandom_range(13)];
        lo = opt[$urandom_range(13)];
        if (r < 45) prog[i] = 16'h8000 | 16'($urandom_range(32767));
        else if (r < 97) prog[i] = {hi, lo};
        else prog[i] = {8'h07, lo};
      end
      prog[n] = 16'h0C0C;
      model_run(16, 16); exp_q[0] = m_out; exp_err[0] = merr; exp_depth[0] = m_depth;
      model_run(4, 16);  exp_q[1] = m_out; exp_err[1] = merr; exp_depth[1] = m_depth;
      model_run(16, 32); exp_q[2] = m_out; exp_err[2] = merr; exp_depth[2] = m_depth;
      do_reset();
      run_all(3000, 70, 70);
      for (int k = 0; k < 3; k++) begin
        gerr = (k == 0) ? int'(a_err) : (k == 1) ? int'(b_err) : int'(c_err);
        gdep = (k == 0) ? int'(a_depth) : (k == 1) ? int'(b_depth) : int'(c_depth);
        checks++;
        if (got_q[k].size() != exp_q[k].size())
          begin failures++; $display("FAIL rnd%0d_core%0d_out_count got=%0d required=%0d", it, k, got_q[k].size(), exp_q[k].size()); end
        for (int i = 0; i < exp_q[k].size() && i < got_q[k].size(); i++) begin
          checks++;
          if (got_q[k][i] !== exp_q[k][i])
            begin failures++; $display("FAIL rnd%0d_core%0d_out%0d got=%0h required=%0h", it, k, i, got_q[k][i], exp_q[k][i]); end
        end
        checks += 2;
        if (gerr != exp_err[k]) begin failures++; $display("FAIL rnd%0d_core%0d_err got=%0d required=%0d", it, k, gerr, exp_err[k]); end
        if (gdep != exp_depth[k]) begin failures++; $display("FAIL rnd%0d_core%0d_depth got=%0d required=%0d", it, k, gdep, exp_depth[k]); end
      end
    end
  endtask

  initial begin
    clear_prog();
    test_reset();
    test_basic();
    test_out_stall();
    test_call_ret();
    test_ret_empty();
    test_ds_overflow();
    test_ds_underflow();
    test_jz();
    test_reset_mid_out();
    test_wide();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_core.md
Name: stack_core

Overview:
- Parametrised next-generation 16-bit-instruction stack processor core.
- Fetches instructions over a req/ack memory handshake.
- Executes literal/call/jump/branch words and packed byte-op pairs on a data stack of configurable width and depth.
- Keeps a separate return stack, streams OUT values over a valid/ready port, and halts with an error code on stack faults.
- Sits between instruction memory and the board-level output/LED logic.

Parameters:
- DATA_W, 16, data stack and out_data width; must be >= 16.
- ADDR_W, 15, word address width of mem_addr and pc; must be >= 13.
- DS_DEPTH, 16, data stack entries; power of two, >= 4.
- RS_DEPTH, 8, return stack entries; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_addr  out  ADDR_W  instruction word address; equals pc.
- mem_req  out  1  fetch request.
- mem_ack  in  1  mem_rdata valid this cycle.
- mem_rdata  in  16  instruction word.
- out_valid  out  DATA_W-wide payload valid.
- out_data  out  DATA_W  value produced by OUT.
- out_ready  in  1  sink accepts out_data.
- halted  out  1  core stopped.
- err  out  2  0 none, 1 DS overflow, 2 DS underflow, 3 RS overflow/underflow.
- ds_depth  out  $clog2(DS_DEPTH)+1  current data stack occupancy (debug).

Behaviour:
- Reset (async, rst_n low):
  - pc=0, state=FETCH, both stacks empty.
  - mem_req=0, out_valid=0, out_data=0, halted=0, err=0.
  - Reset mid-operation aborts any fetch or OUT; a pending OUT value is discarded.
- mem_req = (state==FETCH) and rst_n high. It rises the first cycle after reset release.
- FETCH:
  - On mem_req and mem_ack: latch mem_rdata into ir and set pc <= pc+1, wrapping mod 2^ADDR_W.
  - If ir[15] or ir[15:13] != 0, go to EXEC_W; otherwise go to EXEC_HI.
  - Without mem_ack, wait indefinitely.
- EXEC_W (one cycle, then FETCH):
  - ir[15]=1, LIT: push zero-extended ir[14:0].
  - 010, CALL: push pc onto the return stack; pc <= zero-extended ir[12:0].
  - 011, JMP: pc <= ir[12:0].
  - 001, JZ: pop TOS; if TOS==0, pc <= ir[12:0].
- EXEC_HI then EXEC_LO:
  - EXEC_HI executes byte op ir[15:8]; EXEC_LO executes ir[7:0]; then FETCH.
  - RET in the HI slot skips the LO slot.
- Byte ops (encodings in package):
  - NOP 00.
  - ADD 01: NOS+TOS.
  - SUB 02: NOS-TOS.
  - DUP 03.
  - SWAP 04.
  - DROP 05.
  - OUT 06.
  - RET 07.
  - AND 08, OR 09, XOR 0A.
  - OVER 0B.
  - HALT 0C.
  - Undefined opcodes execute as NOP.
- Arithmetic wraps mod 2^DATA_W. Binary ops pop 2 and push 1.
- OUT:
  - Entering the slot sets out_valid=1 with out_data=TOS, then holds the slot.
  - While out_valid=1 and out_ready=0, out_data stays stable and the core stalls.
  - On the out_valid & out_ready cycle: pop, clear out_valid, advance.
  - out_ready already high on entry still costs one valid cycle.
- Fault checks happen before any state change:
  - Push when full (LIT, DUP, OVER at DS_DEPTH) gives err=1.
  - An op needing more operands than ds_depth (ADD/SUB/AND/OR/XOR/SWAP/OVER need 2; DROP/DUP/OUT/JZ need 1) gives err=2.
  - CALL when RS full, or RET when RS empty, gives err=3.
  - On any fault: halted=1, no stack, pc or out change.
- HALT gives halted=1 with err=0.
- Halted is sticky until reset. No further fetches: mem_req=0.
- Latency with mem_ack tied high: word instruction 2 cycles; byte pair 3 cycles.

Decomposition:
- Package stack_core_pkg holds:
  - state enum (FETCH, EXEC_W, EXEC_HI, EXEC_LO, HALT).
  - word-class and byte opcode constants.
  - error codes.
  - per-opcode operand-need and push-count functions.
- One sub-module, lifo_stack (params WIDTH, DEPTH), is instantiated twice.
  - Interface: push/pop/replace and TOS/NOS read.
  - Flags: full, depth.
  - Simultaneous pop2+push is handled as a pop plus replace of the new TOS.

Test Plan:
- mem_ack=1 always; program LIT 5, LIT 3, {SUB,OUT}, {HALT,NOP}:
  - out_data=2 with out_valid.
  - halted=1, err=0, ds_depth=0.
  - The first LIT completes 2 cycles after reset release.
- Same program with out_ready held low 5 cycles:
  - out_valid stays high and out_data=2 is stable for 6 cycles.
  - pc does not advance.
  - After the handshake, HALT is reached.
- CALL 0x10 at word 0; RET,NOP at 0x10; LIT 7, OUT at word 1:
  - Output 7.
  - The NOP slot is skipped.
- RET, HALT with an empty RS: err=3, halted=1, mem_req=0 thereafter.
- DS_DEPTH=4, five LITs: err=1 on the fifth, ds_depth=4.
- ADD on a one-entry stack: err=2.
- JZ with TOS=0 branches to 0x20; with TOS=1 it falls through.
- rst_n pulsed low mid-OUT stall:
  - out_valid drops immediately.
  - pc=0.
  - Execution restarts from word 0.
- DATA_W=32: LIT 0x7FFF, DUP, ADD → out_data=0xFFFE.
